// File: rtl/tt_um_serial_accum_adder_if.sv
// Operand/result handshake bundle for the digit-serial accumulate adder.
// The producer/consumer side uses the master modport, the adder uses slave.
interface tt_um_serial_accum_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );

endinterface

// File: rtl/tt_um_serial_accum_adder.sv
// Digit-serial add / subtract / accumulate unit.
// One operation per in_valid/in_ready handshake; DIGIT bits are summed per
// cycle LSB first with a registered carry, the committed result is held
// until out_ready. A running accumulator supports multi-operand sums.
// Optional feature macro: SERIAL_ADDER_SAT_EN (clamp result on signed
// overflow; flags still report the unclamped outcome).
module tt_um_serial_accum_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  tt_um_serial_accum_adder_if.slave   bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

`ifdef SERIAL_ADDER_SAT_EN
  // Clamp to the most positive / most negative value on signed overflow.
  // On overflow the true sign is the opposite of the wrapped result's msb.
  function automatic logic [WIDTH-1:0] clamp_result(
    input logic [WIDTH-1:0] raw,
    input logic             ovf
  );
    logic [WIDTH-1:0] res;
    if (ovf) begin
      if (raw[WIDTH-1]) begin
        res = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        res = {1'b1, {(WIDTH-1){1'b0}}};
      end
    end else begin
      res = raw;
    end
    return res;
  endfunction
`endif

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   a_q,         a_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic [WIDTH-1:0]   sum_q,       sum_d;
  logic               carry_q,     carry_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               ovf_q,       ovf_d;
  logic               acc_wr_q,    acc_wr_d;
  logic [WIDTH-1:0]   acc_q,       acc_d;
  logic [WIDTH-1:0]   result_q,    result_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q,  overflow_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q,  in_ready_d;

  logic [DIGIT-1:0]     dig_a_s;
  logic [DIGIT-1:0]     dig_b_s;
  logic [DIGIT:0]       dig_sum_s;
  logic [WIDTH+DIGIT-1:0] sum_cat_s;
  logic [WIDTH-1:0]     final_s;

  // Current digit adder: low DIGIT bits of the shifting operands plus carry.
  always_comb begin
    dig_a_s   = a_q[DIGIT-1:0];
    dig_b_s   = b_q[DIGIT-1:0];
    dig_sum_s = {1'b0, dig_a_s} + {1'b0, dig_b_s} + {{DIGIT{1'b0}}, carry_q};
    sum_cat_s = {dig_sum_s[DIGIT-1:0], sum_q};
`ifdef SERIAL_ADDER_SAT_EN
    final_s   = clamp_result(sum_q, ovf_q);
`else
    final_s   = sum_q;
`endif
  end

  // Next-state and datapath: accept in IDLE, one digit per CALC cycle, commit, then hold.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    acc_wr_d    = acc_wr_q;
    acc_d       = acc_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // CLR forces A to zero so the same adder yields result 0.
          if (bus.mode == MODE_CLR) begin
            a_d = {WIDTH{1'b0}};
          end else begin
            a_d = bus.op_a;
          end
          case (bus.mode)
            MODE_ADD: b_d = bus.op_b;
            MODE_SUB: b_d = ~bus.op_b;
            MODE_ACC: b_d = acc_q;
            MODE_CLR: b_d = {WIDTH{1'b0}};
            default:  b_d = {WIDTH{1'b0}};
          endcase
          carry_d     = (bus.mode == MODE_SUB);
          acc_wr_d    = bus.mode[1];
          sum_d       = {WIDTH{1'b0}};
          ovf_d       = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = ST_CALC;
          in_ready_d  = 1'b0;
        end else begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
        end
      end

      ST_CALC: begin
        if (cnt_q != CNT_W'(N)) begin
          // Result digits enter at the top and shift down, so after N
          // digits the least significant one sits at bit 0.
          sum_d   = sum_cat_s[WIDTH+DIGIT-1:DIGIT];
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          carry_d = dig_sum_s[DIGIT];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            // Top digit: its msbs are the operand sign bits.
            ovf_d = (dig_a_s[DIGIT-1] == dig_b_s[DIGIT-1]) &&
                    (dig_sum_s[DIGIT-1] != dig_a_s[DIGIT-1]);
          end else begin
            ovf_d = ovf_q;
          end
        end else begin
          // Commit edge: publish the result and enter HOLD.
          result_d    = final_s;
          carry_out_d = carry_q;
          overflow_d  = ovf_q;
          if (acc_wr_q) begin
            acc_d = final_s;
          end else begin
            acc_d = acc_q;
          end
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = ST_HOLD;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      acc_wr_q    <= 1'b0;
      acc_q       <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      acc_wr_q    <= acc_wr_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_tt_um_serial_accum_adder.sv
// Directed bench for tt_um_serial_accum_adder (WIDTH=16, DIGIT=4).
module tb_tt_um_serial_accum_adder;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  tt_um_serial_accum_adder_if #(.WIDTH(16)) bus ();

  tt_um_serial_accum_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op, wait for acceptance, then count edges until out_valid.
  task automatic run_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a     = 16'hDEAD;
    bus.op_b     = 16'hBEEF;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Full op with checks on result, flags and latency, then hand the result off.
  task automatic op_check(input string tag, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic exp_co, input logic exp_ov);
    int lat;
    run_op(m, a, b, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_res"}, 32'(bus.result), 32'(exp_res));
    chk({tag, "_co"},  32'(bus.carry_out), 32'(exp_co));
    chk({tag, "_ov"},  32'(bus.overflow), 32'(exp_ov));
    release_out();
  endtask

  initial begin
    int lat;
    n_vec = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = 16'h0000;
    bus.op_b      = 16'h0000;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.result), 32'd0);
    chk("rst_carry",     32'(bus.carry_out), 32'd0);
    chk("rst_ovf",       32'(bus.overflow), 32'd0);

    // 1. Basic add, 5-cycle latency, handshake release
    op_check("t1_add", 2'b00, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    chk("t1_in_ready_after",  32'(bus.in_ready), 32'd1);
    chk("t1_out_valid_after", 32'(bus.out_valid), 32'd0);

    // 2. Unsigned carry and borrow
    op_check("t2_add_wrap", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    op_check("t2_sub_borrow", 2'b01, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);

    // 3. Signed overflow, wrapped or clamped
`ifdef SERIAL_ADDER_SAT_EN
    op_check("t3_add_ovf", 2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    op_check("t3_sub_ovf", 2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1);
`else
    op_check("t3_add_ovf", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    op_check("t3_sub_ovf", 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
`endif

    // 4. Clear, accumulate three times, then ADD leaves acc alone
    op_check("t4_clr",  2'b11, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0);
    op_check("t4_acc1", 2'b10, 16'h0010, 16'hFFFF, 16'h0010, 1'b0, 1'b0);
    op_check("t4_acc2", 2'b10, 16'h0010, 16'hFFFF, 16'h0020, 1'b0, 1'b0);
    op_check("t4_acc3", 2'b10, 16'h0010, 16'hFFFF, 16'h0030, 1'b0, 1'b0);
    op_check("t4_add",  2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    op_check("t4_acc_read", 2'b10, 16'h0000, 16'h0000, 16'h0030, 1'b0, 1'b0);

    // 5. Back-pressure in HOLD with a competing request
    run_op(2'b00, 16'h0100, 16'h0020, lat);
    chk("t5_lat", 32'(lat), 32'd5);
    chk("t5_res", 32'(bus.result), 32'h0120);
    bus.in_valid = 1'b1;
    bus.mode     = 2'b00;
    bus.op_a     = 16'hAAAA;
    bus.op_b     = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5_hold_res",       32'(bus.result), 32'h0120);
      chk("t5_hold_in_ready",  32'(bus.in_ready), 32'd0);
      chk("t5_hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    release_out();
    chk("t5_rel_in_ready",  32'(bus.in_ready), 32'd1);
    chk("t5_rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rel_res",       32'(bus.result), 32'h0120);
    repeat (7) @(posedge clk);
    #1 chk("t5_not_accepted", 32'(bus.out_valid), 32'd0);

    // 6. Reset in the middle of CALC (during digit 2)
    bus.in_valid = 1'b1;
    bus.mode     = 2'b00;
    bus.op_a     = 16'h1111;
    bus.op_b     = 16'h2222;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_in_ready",  32'(bus.in_ready), 32'd1);
    chk("t6_result",    32'(bus.result), 32'd0);
    repeat (6) @(posedge clk);
    #1 chk("t6_no_late_out", 32'(bus.out_valid), 32'd0);
    op_check("t6_acc_zero", 2'b10, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    op_check("t6_add", 2'b00, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
